// File: rtl/word_fetch_pkg.sv
// Shared definitions for the word fetch sequencer: FSM states, operand size
// codes and downstream data-register function selects.
package word_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HALF  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] SIZE_WORD2 = 2'b11;

  localparam logic [1:0] FS_SEXT = 2'b00;
  localparam logic [1:0] FS_ZEXT = 2'b01;
  localparam logic [1:0] FS_SHL  = 2'b10;
  localparam logic [1:0] FS_SHR  = 2'b11;

  // Index of the highest byte of the operand, i.e. N-1.
  function automatic logic [1:0] last_index(input logic [1:0] size);
    case (size)
      SIZE_BYTE: last_index = 2'd0;
      SIZE_HALF: last_index = 2'd1;
      default:   last_index = 2'd3;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = addr_lo[0];
      default:   misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/word_fetch_sequencer.sv
// Fetches a 1/2/4-byte little-endian operand one byte at a time, highest address
// first, steering a downstream shift register. Optional: WORD_FETCH_ALIGN_CHECK_EN.
module word_fetch_sequencer
  import word_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] BaseAddr,
  input  logic [1:0]            Size,
  input  logic                  SignExt,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic                  MemRead,
  input  logic [7:0]            MemData,
  input  logic                  MemReady,
  output logic [7:0]            DRByte,
  output logic                  DREnable,
  output logic [1:0]            DRFunSel,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [1:0]            cnt_reg;
  logic                  sext_reg;
  logic                  first_reg;
  logic [7:0]            dr_byte_reg;
  logic                  align_fault;

`ifdef WORD_FETCH_ALIGN_CHECK_EN
  assign align_fault = misaligned(Size, BaseAddr[1:0]);
`else
  assign align_fault = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg   <= ST_IDLE;
      base_reg    <= '0;
      cnt_reg     <= 2'd0;
      sext_reg    <= 1'b0;
      first_reg   <= 1'b0;
      dr_byte_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (Start && !align_fault) begin
            base_reg  <= BaseAddr;
            cnt_reg   <= last_index(Size);
            sext_reg  <= SignExt;
            first_reg <= 1'b1;
          end
        end
        ST_REQ: begin
          if (MemReady) dr_byte_reg <= MemData;
        end
        ST_WRITE: begin
          first_reg <= 1'b0;
          if (cnt_reg != 2'd0) cnt_reg <= cnt_reg - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    MemRead    = 1'b0;
    MemAddr    = '0;
    DREnable   = 1'b0;
    DRFunSel   = FS_SEXT;
    Done       = 1'b0;
    Error      = 1'b0;
    Busy       = (state_reg != ST_IDLE);
    case (state_reg)
      ST_IDLE: begin
        if (Start) state_next = align_fault ? ST_ERR : ST_REQ;
      end
      ST_REQ: begin
        MemRead = 1'b1;
        // Address is base + counter, wrapping naturally at 2^ADDR_WIDTH.
        MemAddr = base_reg + {{(ADDR_WIDTH-2){1'b0}}, cnt_reg};
        if (MemReady) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        DREnable = 1'b1;
        if (first_reg) DRFunSel = sext_reg ? FS_SEXT : FS_ZEXT;
        else           DRFunSel = FS_SHL;
        state_next = (cnt_reg == 2'd0) ? ST_DONE : ST_REQ;
      end
      ST_DONE: begin
        Done       = 1'b1;
        state_next = ST_IDLE;
      end
`ifdef WORD_FETCH_ALIGN_CHECK_EN
      ST_ERR: begin
        Error      = 1'b1;
        state_next = ST_IDLE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  assign DRByte = dr_byte_reg;

endmodule

// File: tb/tb_word_fetch_sequencer.sv
// Directed bench for word_fetch_sequencer: table of loads plus hand-written
// reset-abort, address-wrap/alignment and held-Start sequences.
module tb_word_fetch_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [31:0] BaseAddr;
  logic [1:0]  Size;
  logic        SignExt;
  logic [31:0] MemAddr;
  logic        MemRead;
  logic [7:0]  MemData;
  logic        MemReady;
  logic [7:0]  DRByte;
  logic        DREnable;
  logic [1:0]  DRFunSel;
  logic        Busy;
  logic        Done;
  logic        Error;

  int errors = 0;
  int checks = 0;
  logic [31:0] dr_model = 32'd0;
  logic [31:0] seen_addr [4];

  word_fetch_sequencer #(.ADDR_WIDTH(32)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .BaseAddr(BaseAddr),
    .Size(Size), .SignExt(SignExt), .MemAddr(MemAddr), .MemRead(MemRead),
    .MemData(MemData), .MemReady(MemReady), .DRByte(DRByte),
    .DREnable(DREnable), .DRFunSel(DRFunSel), .Busy(Busy), .Done(Done),
    .Error(Error)
  );

  always #5 Clock = ~Clock;

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h100: mem_rd = 8'h11;
      32'h101: mem_rd = 8'h22;
      32'h102: mem_rd = 8'h33;
      32'h103: mem_rd = 8'h44;
      32'h104: mem_rd = 8'h01;
      32'h105: mem_rd = 8'h02;
      32'h106: mem_rd = 8'h03;
      32'h107: mem_rd = 8'h84;
      32'h200: mem_rd = 8'h80;
      32'h300: mem_rd = 8'h34;
      32'h301: mem_rd = 8'h92;
      32'h302: mem_rd = 8'h7F;
      32'h303: mem_rd = 8'hC5;
      default: mem_rd = a[7:0] ^ 8'hA5;
    endcase
  endfunction

  assign MemData = mem_rd(MemAddr);

  // Downstream data register: captures on the edge that ends a WRITE cycle.
  always @(posedge Clock) begin
    if (DREnable) begin
      case (DRFunSel)
        2'b00:   dr_model <= {{24{DRByte[7]}}, DRByte};
        2'b01:   dr_model <= {24'd0, DRByte};
        2'b10:   dr_model <= {dr_model[23:0], DRByte};
        default: dr_model <= {DRByte, dr_model[31:8]};
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one load, models MemReady wait states and checks every observed cycle.
  task automatic run_load(input string name, input logic [31:0] base, input logic [1:0] size,
                          input logic sext, input int waits, input logic [31:0] exp_dr,
                          input int exp_done);
    int n, writes, done_edge, wl;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    writes = 0; done_edge = -1; wl = waits;
    BaseAddr = base; Size = size; SignExt = sext; Start = 1'b1;
    MemReady = (waits == 0);
    for (int e = 0; e <= 60 && done_edge < 0; e++) begin
      @(posedge Clock); #1;
      if (e == 0) Start = 1'b0;
      if (MemRead && DREnable) check({name, " rd_and_en"}, 32'd1, 32'd0);
      if (DREnable) begin
        check({name, " funsel"}, {30'd0, DRFunSel},
              (writes == 0) ? (sext ? 32'd0 : 32'd1) : 32'd2);
        writes++;
      end
      if (Done) done_edge = e;
      if (MemRead) begin
        check({name, " addr"}, MemAddr, base + 32'(n - 1 - writes));
        if (writes < 4) seen_addr[writes] = MemAddr;
        if (wl > 0) begin MemReady = 1'b0; wl--; end
        else begin MemReady = 1'b1; wl = waits; end
      end else begin
        MemReady = (waits == 0);
      end
    end
    check({name, " done_edge"}, 32'(done_edge), 32'(exp_done));
    check({name, " writes"}, 32'(writes), 32'(n));
    check({name, " dr"}, dr_model, exp_dr);
    @(posedge Clock); #1;
    check({name, " idle_busy"}, {31'd0, Busy}, 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] base;
    logic [1:0]  size;
    logic        sext;
    int          waits;
    logic [31:0] exp_dr;
    int          exp_done;
  } vec_t;

  vec_t vecs [6];
  int   done_cnt, rd_cnt;

  initial begin
    vecs[0] = '{"word_zext",  32'h100, 2'b10, 1'b0, 0, 32'h44332211,  8};
    vecs[1] = '{"byte_sext",  32'h200, 2'b00, 1'b1, 0, 32'hFFFFFF80,  2};
    vecs[2] = '{"byte_zext",  32'h200, 2'b00, 1'b0, 0, 32'h00000080,  2};
    vecs[3] = '{"half_wait",  32'h300, 2'b01, 1'b1, 3, 32'hFFFF9234, 10};
    vecs[4] = '{"size11_w1",  32'h104, 2'b11, 1'b1, 1, 32'h84030201, 12};
    vecs[5] = '{"half_zext",  32'h302, 2'b01, 1'b0, 0, 32'h0000C57F,  4};

    Reset = 1'b1; Start = 1'b0; BaseAddr = 32'd0; Size = 2'b00; SignExt = 1'b0;
    MemReady = 1'b1;
    @(posedge Clock); #1;
    check("reset outputs", {MemAddr[15:0], DRByte, 2'b0, DRFunSel, MemRead, DREnable, Busy, Done},
          32'd0);
    check("reset error", {31'd0, Error}, 32'd0);
    Reset = 1'b0;
    @(posedge Clock); #1;

    for (int i = 0; i < 6; i++)
      run_load(vecs[i].name, vecs[i].base, vecs[i].size, vecs[i].sext,
               vecs[i].waits, vecs[i].exp_dr, vecs[i].exp_done);

    // Abort a 4-byte load with reset during its second WRITE cycle.
    BaseAddr = 32'h100; Size = 2'b10; SignExt = 1'b0; MemReady = 1'b1; Start = 1'b1;
    @(posedge Clock); #1; Start = 1'b0;
    repeat (3) @(posedge Clock);
    #1 check("abort in_write", {31'd0, DREnable}, 32'd1);
    #2 Reset = 1'b1;
    #1 check("abort async", {MemAddr, 3'd0, DRByte == 8'd0, DRFunSel, MemRead, DREnable, Busy, Done, Error},
             {32'd0, 3'd0, 1'b1, 2'b00, 5'd0});
    @(posedge Clock); #1 Reset = 1'b0;
    done_cnt = 0; rd_cnt = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge Clock); #1;
      if (Done) done_cnt++;
      if (DREnable || MemRead || Busy) rd_cnt++;
    end
    check("abort no_done", 32'(done_cnt), 32'd0);
    check("abort quiet", 32'(rd_cnt), 32'd0);
    run_load("after_abort", 32'h100, 2'b10, 1'b0, 0, 32'h44332211, 8);

    // Address wrap at the top of the address space.
`ifdef WORD_FETCH_ALIGN_CHECK_EN
    BaseAddr = 32'hFFFFFFFE; Size = 2'b10; SignExt = 1'b0; Start = 1'b1;
    @(posedge Clock); #1; Start = 1'b0;
    check("align error", {29'd0, Error, Busy, MemRead}, 32'b110);
    @(posedge Clock); #1;
    check("align after", {29'd0, Error, Busy, MemRead | DREnable}, 32'd0);
`else
    run_load("wrap", 32'hFFFFFFFE, 2'b10, 1'b0, 0, 32'hA4A55A5B, 8);
    check("wrap a0", seen_addr[0], 32'h00000001);
    check("wrap a1", seen_addr[1], 32'h00000000);
    check("wrap a2", seen_addr[2], 32'hFFFFFFFF);
    check("wrap a3", seen_addr[3], 32'hFFFFFFFE);
`endif

    // Start held high: accepted only in IDLE, one Done per load.
    BaseAddr = 32'h200; Size = 2'b00; SignExt = 1'b1; MemReady = 1'b1; Start = 1'b1;
    done_cnt = 0; rd_cnt = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge Clock); #1;
      if (Done) done_cnt++;
      if (MemRead) rd_cnt++;
      if (e == 3) check("held idle_gap", {31'd0, Busy}, 32'd0);
      if (e == 4) check("held reaccept", {31'd0, MemRead}, 32'd1);
    end
    Start = 1'b0;
    check("held dones", 32'(done_cnt), 32'd3);
    check("held reads", 32'(rd_cnt), 32'd3);
    check("held dr", dr_model, 32'hFFFFFF80);
    repeat (4) @(posedge Clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
